// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: one chip-select frame carries a command byte, an
// address byte and 0-7 read bytes. Each read byte is returned on a one-cycle strobe.
module spi_burst_master #(
  parameter int CLK_DIV    = 4,
  parameter int BYTE_DELAY = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_cmd,
  input  logic [7:0] i_addr,
  input  logic [2:0] i_rd_len,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic [2:0] o_rd_idx,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs_n
);

  localparam int DIV_MAX = (CLK_DIV > BYTE_DELAY) ? CLK_DIV : BYTE_DELAY;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_DELAY - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, GAP, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       addr_q, addr_d;
  logic [2:0]       len_q, len_d;
  logic             byte_end;

  logic       sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic       busy_q, busy_d, done_q, done_d, rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [2:0] rd_idx_q, rd_idx_d;

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Data path registers carry no reset; they are reloaded on every acceptance
  always_ff @(posedge i_clk) begin
    tx_q   <= tx_d;
    rx_q   <= rx_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    addr_d   = addr_q;
    len_d    = len_q;
    byte_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOW;
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = i_cmd;
          addr_d  = i_addr;
          len_d   = i_rd_len;
        end
      end
      LOW: begin
        if (div_q == DIV_LAST) begin
          state_d = HIGH;
          div_d   = '0;
          rx_d    = {rx_q[6:0], i_miso};
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            byte_end = 1'b1;
            bit_d    = '0;
            if (byte_q == {1'b0, len_q} + 4'd1) begin
              state_d = HOLD;
            end else begin
              byte_d  = byte_q + 4'd1;
              tx_d    = (byte_q == 4'd0) ? addr_q : 8'h00;
              state_d = (BYTE_DELAY == 0) ? LOW : GAP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            state_d = LOW;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = LOW;
          div_d   = '0;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state so they register in step with it
  always_comb begin
    sclk_d     = (state_d == HIGH);
    cs_n_d     = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == HOLD) && (state_d == IDLE);
    mosi_d     = mosi_q;
    if (state_d == LOW) begin
      mosi_d = tx_d[7];
    end else if (state_d == HOLD || state_d == IDLE) begin
      mosi_d = 1'b0;
    end
    rd_valid_d = byte_end && (byte_q >= 4'd2);
    rd_data_d  = rd_valid_d ? rx_q : rd_data_q;
    rd_idx_d   = rd_valid_d ? 3'(byte_q - 4'd2) : rd_idx_q;
  end

  assign o_sclk     = sclk_q;
  assign o_mosi     = mosi_q;
  assign o_cs_n     = cs_n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_idx   = rd_idx_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: three instances with different clock divider and
// byte gap settings, a byte-level slave model and a per-cycle protocol monitor.
module tb_spi_burst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start;
  logic [7:0] cmd, addr;
  logic [2:0] len;
  logic       miso [3];
  logic       busy [3], done [3], rv [3], sclk [3], mosi [3], csn [3];
  logic [7:0] rdd [3];
  logic [2:0] rdi [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_burst_master #(
      .CLK_DIV   ((g == 0) ? 2 : (g == 1) ? 1 : 3),
      .BYTE_DELAY((g == 1) ? 5 : 0)
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start[g]),
      .i_cmd     (cmd),
      .i_addr    (addr),
      .i_rd_len  (len),
      .o_busy    (busy[g]),
      .o_done    (done[g]),
      .o_rd_data (rdd[g]),
      .o_rd_valid(rv[g]),
      .o_rd_idx  (rdi[g]),
      .o_sclk    (sclk[g]),
      .o_mosi    (mosi[g]),
      .i_miso    (miso[g]),
      .o_cs_n    (csn[g])
    );
  end

  function automatic int cdv(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction
  function automatic int bdv(input int i);
    return (i == 1) ? 5 : 0;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string nm, input int got, input int want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", nm, got, got, want, want, $time);
    end
  endtask

  // Slave and monitor state for the instance currently under test
  int         act;
  bit         in_burst;
  int         rises, cs_low, done_cnt, rv_cnt, exp_len;
  logic [7:0] mosi_by [9];
  logic [7:0] slv [9];
  logic       prev_sclk [3], prev_mosi [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        chk(busy[i] == !csn[i], "busy_vs_csn", int'(busy[i]), int'(!csn[i]));
        chk(!(csn[i] && sclk[i]), "sclk_idle_low", int'(sclk[i]), 0);
        if (prev_sclk[i] && sclk[i])
          chk(mosi[i] == prev_mosi[i], "mosi_stable_high", int'(mosi[i]), int'(prev_mosi[i]));
        if (i == act) begin
          if (!csn[i]) cs_low++;
          if (sclk[i] && !prev_sclk[i]) begin
            if (rises < 72) mosi_by[rises / 8][7 - rises % 8] = mosi[i];
            rises++;
          end
          if (rv[i]) begin
            chk(in_burst && rv_cnt < exp_len, "rd_valid_expected", rv_cnt, exp_len);
            if (rv_cnt < 7) begin
              chk(rdi[i] == 3'(rv_cnt), "rd_idx", int'(rdi[i]), rv_cnt);
              chk(rdd[i] == slv[2 + rv_cnt], "rd_data", int'(rdd[i]), int'(slv[2 + rv_cnt]));
            end
            chk(rises == 8 * (3 + rv_cnt), "rd_valid_timing", rises, 8 * (3 + rv_cnt));
            rv_cnt++;
          end
          if (done[i]) begin
            chk(in_burst, "done_expected", 0, 1);
            done_cnt++;
          end
        end else begin
          chk(!rv[i] && !done[i], "other_instance_quiet", int'(rv[i] | done[i]), 0);
        end
      end
      prev_sclk[i] = sclk[i];
      prev_mosi[i] = mosi[i];
    end
    for (int i = 0; i < 3; i++)
      miso[i] = (i == act && rises < 72) ? slv[rises / 8][7 - rises % 8] : 1'b0;
  end

  // Runs one burst from acceptance to o_done; called just after a falling edge
  task automatic burst(input int i, input logic [7:0] c, input logic [7:0] a,
                       input logic [2:0] l, input int mid, input int lit_low);
    int b, expv, cyc;
    logic [7:0] eb;
    b    = 2 + int'(l);
    expv = b * 16 * cdv(i) + (b - 1) * bdv(i) + cdv(i);
    act = i; rises = 0; cs_low = 0; done_cnt = 0; rv_cnt = 0; exp_len = int'(l); in_burst = 1;
    for (int k = 0; k < 9; k++) mosi_by[k] = 8'h00;
    cmd = c; addr = a; len = l; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0; cmd = ~c; addr = ~a; len = ~l;
    chk(csn[i] == 1'b0, "cs_low_after_accept", int'(csn[i]), 0);
    chk(busy[i] == 1'b1, "busy_after_accept", int'(busy[i]), 1);
    chk(mosi[i] == c[7], "first_mosi_bit", int'(mosi[i]), int'(c[7]));
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      if (mid > 0 && cyc == mid) begin
        start[i] = 1'b1; cmd = 8'hFF; addr = 8'hFF; len = 3'd7;
      end else if (mid > 0 && cyc == mid + 1) begin
        start[i] = 1'b0;
      end
    end
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    chk(cs_low == expv, "cs_low_cycles", cs_low, expv);
    if (lit_low > 0) chk(cs_low == lit_low, "cs_low_literal", cs_low, lit_low);
    chk(rises == 8 * b, "sclk_rises", rises, 8 * b);
    chk(rv_cnt == int'(l), "rd_valid_count", rv_cnt, int'(l));
    for (int k = 0; k < b; k++) begin
      eb = (k == 0) ? c : (k == 1) ? a : 8'h00;
      chk(mosi_by[k] == eb, "mosi_byte", int'(mosi_by[k]), int'(eb));
    end
    chk(csn[i] && !busy[i], "idle_in_done_cycle", int'(csn[i]), 1);
    in_burst = 0;
  endtask

  initial begin
    rst = 1'b1; start = '0; cmd = '0; addr = '0; len = '0;
    act = 0; in_burst = 0; rises = 0; cs_low = 0; done_cnt = 0; rv_cnt = 0; exp_len = 0;
    for (int i = 0; i < 3; i++) begin
      prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0; miso[i] = 1'b0;
    end
    for (int k = 0; k < 9; k++) begin
      slv[k] = 8'h00; mosi_by[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(!busy[i] && !done[i] && !rv[i], "reset_ctrl", int'(busy[i] | done[i] | rv[i]), 0);
      chk(rdd[i] == 8'h00 && rdi[i] == 3'd0, "reset_rd", int'(rdd[i]), 0);
      chk(!sclk[i] && !mosi[i] && csn[i], "reset_pins", int'(csn[i]), 1);
    end
    rst = 1'b0;
    @(negedge clk); #1;

    // Three-byte read with MISO garbage during command and address
    slv[0] = 8'hA5; slv[1] = 8'h3C; slv[2] = 8'h12; slv[3] = 8'h34; slv[4] = 8'h56;
    burst(0, 8'h0B, 8'h08, 3'd3, 0, 162);

    // Zero-length read
    burst(0, 8'h0A, 8'h2D, 3'd0, 0, 66);
    chk(rises == 16, "zero_len_rises", rises, 16);

    // Single-cycle divider with byte gaps
    slv[2] = 8'hC3;
    burst(1, 8'h9F, 8'h01, 3'd1, 0, 59);

    // Mid-burst start ignored, then a start in the done cycle accepted
    slv[2] = 8'h77; slv[3] = 8'h88;
    burst(0, 8'h03, 8'h10, 3'd2, 40, 0);
    burst(0, 8'h05, 8'h20, 3'd1, 0, 0);
    repeat (3) @(negedge clk);
    #1;

    // Reset in the middle of a burst
    act = 0; in_burst = 0; rises = 0;
    cmd = 8'hC7; addr = 8'h11; len = 3'd2; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk(csn[0] == 1'b0, "mid_burst_cs_low", int'(csn[0]), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk(csn[0] && !sclk[0] && !busy[0], "abort_pins", int'(csn[0]), 1);
    chk(!done[0] && !rv[0], "abort_no_strobes", int'(done[0] | rv[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk(csn[0] && !busy[0] && !sclk[0], "idle_after_reset", int'(csn[0]), 1);

    // Random bursts on the CLK_DIV=3 instance under the mode-0 monitor
    for (int r = 0; r < 2; r++) begin
      logic [7:0] rc, ra;
      logic [2:0] rl;
      rc = 8'($urandom); ra = 8'($urandom); rl = 3'($urandom_range(1, 7));
      slv[0] = 8'($urandom); slv[1] = 8'($urandom);
      for (int k = 2; k < 9; k++) slv[k] = 8'($urandom);
      burst(2, rc, ra, rl, 0, 0);
      repeat (2) @(negedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
